// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/EX memory-port arbiter: FSM states, response owner
// and access sizes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Wide enough for the largest supported starvation limit (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Grant decision between instruction and data requesters: data wins by default,
// instruction wins once it has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter_prio_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant,
    output logic grant_inst,
    output logic grant_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_limit_hit;

    assign w_limit_hit = (r_starve_cnt == LIMIT);
    assign grant_inst  = grant & inst_req & (~data_req | w_limit_hit);
    assign grant_data  = grant & data_req & ~grant_inst;

    // Only data grants that leave an instruction request waiting count as starvation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (grant_inst) begin
            r_starve_cnt <= '0;
        end else if (grant_data) begin
            if (!inst_req)
                r_starve_cnt <= '0;
            else if (!w_limit_hit)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the IF instruction requester and the
// EX/ME data requester; one transaction in flight, responses steered to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    owner_t            r_owner;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_arb_en;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_resp;

    // Gating with resetn keeps the combinational addr_ok outputs low during reset.
    assign w_arb_en = (r_state == ARB_IDLE) & resetn;
    assign w_resp   = (r_state == ARB_WAIT) & mem_data_ok;

    mem_port_arbiter_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_sel (
        .clk       (clk),
        .resetn    (resetn),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .grant     (w_arb_en),
        .grant_inst(w_grant_inst),
        .grant_data(w_grant_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ARB_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant_inst | w_grant_data) w_state_next = ARB_REQ;
            ARB_REQ:  if (mem_addr_ok)                 w_state_next = ARB_WAIT;
            ARB_WAIT: if (mem_data_ok)                 w_state_next = ARB_IDLE;
            default:                                   w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= OWN_DATA;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_inst) begin
            r_owner <= OWN_INST;
            r_wr    <= inst_wr;
            r_size  <= inst_size;
            r_wstrb <= inst_wstrb;
            r_addr  <= inst_addr;
            r_wdata <= inst_wdata;
        end else if (w_grant_data) begin
            r_owner <= OWN_DATA;
            r_wr    <= data_wr;
            r_size  <= data_size;
            r_wstrb <= data_wstrb;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
        end
    end

    always_comb begin
        mem_req      = (r_state == ARB_REQ);
        inst_addr_ok = w_grant_inst;
        data_addr_ok = w_grant_data;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        if (w_resp) begin
            if (r_owner == OWN_INST) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end else begin
                data_data_ok = 1'b1;
                data_rdata   = mem_rdata;
            end
        end
    end

    assign mem_wr    = r_wr;
    assign mem_size  = r_size;
    assign mem_wstrb = r_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbitration model predicts each
// grant and payload, a memory model answers and queues the expected responses.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        own;   // 1 = data requester
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   n_inst_g = 0, n_data_g = 0, n_resp = 0, n_inst_ok = 0, n_data_ok = 0;
    int   seen_ig = 0, seen_dg = 0, lost = 0;
    bit   idle_m = 1'b1;
    bit   rsp_seen;
    bit   win_inst;
    int   streak = 0;
    logic grant_log[$];
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    acc_t acc_e;
    rsp_t rsp_e;

    bit          rand_dly = 1'b0;
    int          addr_dly_cfg = 0, data_dly_cfg = 0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;
    int          stray_idle_arm = 0, stray_idle_done = 0;
    int          stray_req_arm = 0, stray_req_done = 0;
    int          abort_arm = 0, abort_done = 0, late_done = 0;
    bit          in_wait = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: grants, starvation rule, scoreboard of responses
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("reset_outputs",
                    {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_rdata, data_rdata}, '0);
                acc_q.delete();
                rsp_q.delete();
                idle_m = 1'b1;
                streak = 0;
            end else begin
                rsp_seen = 1'b0;
                if (inst_data_ok || data_data_ok) begin
                    rsp_seen = 1'b1;
                    n_resp++;
                    if (inst_data_ok) n_inst_ok++;
                    if (data_data_ok) n_data_ok++;
                    chk("single_data_ok", {inst_data_ok, data_data_ok} == 2'b11, 1'b0);
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
                    end else begin
                        rsp_e = rsp_q.pop_front();
                        chk("resp_owner", {inst_data_ok, data_data_ok}, rsp_e.own ? 2'b01 : 2'b10);
                        chk("resp_rdata", inst_data_ok ? inst_rdata : data_rdata, rsp_e.rdata);
                        $display("resp  own=%s rdata=%08h", rsp_e.own ? "D" : "I", rsp_e.rdata);
                    end
                end
                if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 32'h0);
                if (!data_data_ok) chk("data_rdata_zero", data_rdata, 32'h0);

                if (idle_m && (inst_req || data_req)) begin
                    win_inst = inst_req && (!data_req || streak == LIMIT);
                    chk("grant", {inst_addr_ok, data_addr_ok}, win_inst ? 2'b10 : 2'b01);
                    if (win_inst) begin
                        acc_q.push_back({1'b0, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata});
                        streak = 0;
                        n_inst_g++;
                    end else begin
                        acc_q.push_back({1'b1, data_wr, data_size, data_wstrb, data_addr, data_wdata});
                        streak = inst_req ? streak + 1 : 0;
                        n_data_g++;
                    end
                    grant_log.push_back(win_inst);
                    $display("grant %s", win_inst ? "I" : "D");
                    idle_m = 1'b0;
                end else begin
                    chk("no_grant", {inst_addr_ok, data_addr_ok}, 2'b00);
                end
                if (rsp_seen) idle_m = 1'b1;
            end
        end
    end

    // Memory model: sole driver of mem_addr_ok / mem_data_ok / mem_rdata
    initial begin
        int da, dd;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        forever begin
            tick();
            if (resetn && mem_req) begin
                da = rand_dly ? int'($urandom_range(0, 3)) : addr_dly_cfg;
                dd = rand_dly ? int'($urandom_range(0, 3)) : data_dly_cfg;
                if (stray_req_arm != stray_req_done) begin
                    stray_req_done++;
                    mem_data_ok = 1'b1;
                    mem_rdata   = 32'h5A5A_5A5A;
                    tick();
                    mem_data_ok = 1'b0;
                    mem_rdata   = 32'h0;
                    da = da + 1;
                end
                for (int i = 0; i < da; i++) begin
                    chk("hold_mem_req", mem_req, 1'b1);
                    if (acc_q.size() > 0)
                        chk("hold_payload", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                            {acc_q[0].wr, acc_q[0].size, acc_q[0].wstrb, acc_q[0].addr, acc_q[0].wdata});
                    tick();
                end
                chk("req_mem_req", mem_req, 1'b1);
                if (acc_q.size() == 0) begin
                    chk("payload_without_grant", 1'b1, 1'b0);
                    acc_e = '0;
                end else begin
                    acc_e = acc_q.pop_front();
                    chk("payload", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                        {acc_e.wr, acc_e.size, acc_e.wstrb, acc_e.addr, acc_e.wdata});
                end
                mem_addr_ok = 1'b1;
                tick();
                mem_addr_ok = 1'b0;
                if (abort_arm != abort_done) begin
                    abort_done++;
                    in_wait = 1'b1;
                    wait (!resetn);
                    wait (resetn);
                    in_wait = 1'b0;
                    tick();
                    tick();
                    mem_rdata   = $urandom;
                    mem_data_ok = 1'b1;
                    tick();
                    mem_data_ok = 1'b0;
                    mem_rdata   = 32'h0;
                    late_done++;
                end else begin
                    for (int i = 0; i < dd; i++) tick();
                    mem_rdata   = use_fixed ? fixed_rdata : $urandom;
                    mem_data_ok = 1'b1;
                    rsp_q.push_back({acc_e.own, mem_rdata});
                    tick();
                    mem_data_ok = 1'b0;
                    mem_rdata   = 32'h0;
                end
            end else if (stray_idle_arm != stray_idle_done) begin
                stray_idle_done++;
                mem_data_ok = 1'b1;
                mem_rdata   = 32'hA5A5_A5A5;
                tick();
                mem_data_ok = 1'b0;
                mem_rdata   = 32'h0;
            end
        end
    end

    task automatic new_inst();
        inst_req   = 1'b1;
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    // mode 0: no new requests, 1: random requests, 2: both requesters always pending
    task automatic step(input int mode);
        tick();
        if (n_inst_g != seen_ig) begin seen_ig = n_inst_g; inst_req = 1'b0; end
        if (n_data_g != seen_dg) begin seen_dg = n_data_g; data_req = 1'b0; end
        if (mode == 2) begin
            if (!inst_req) new_inst();
            if (!data_req) new_data();
        end else if (mode == 1) begin
            if (!inst_req && $urandom_range(0, 3) == 0) new_inst();
            if (!data_req && $urandom_range(0, 2) == 0) new_data();
        end
    endtask

    task automatic drain();
        int c = 0;
        while (c < 800 && (inst_req || data_req || n_resp != n_inst_g + n_data_g - lost)) begin
            step(0);
            c++;
        end
        chk("drain_timeout", n_resp == n_inst_g + n_data_g - lost, 1'b1);
    endtask

    initial begin
        int r0, i0, d0, g0, c;
        resetn = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        #2 resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        step(0);

        // Single data read
        addr_dly_cfg = 1; data_dly_cfg = 2; use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
        i0 = n_inst_ok; d0 = n_data_ok;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h1C00_0100; data_wdata = 32'h0;
        drain();
        chk("t1_data_ok_count", 32'(n_data_ok - d0), 32'd1);
        chk("t1_inst_ok_count", 32'(n_inst_ok - i0), 32'd0);
        use_fixed = 1'b0;

        // Simultaneous requests: data first, then inst
        g0 = grant_log.size();
        new_inst();
        new_data();
        drain();
        chk("t2_grants", 32'(grant_log.size() - g0), 32'd2);
        if (grant_log.size() >= g0 + 2)
            chk("t2_order", {grant_log[g0], grant_log[g0+1]}, 2'b01);

        // Both held high: inst wins every (LIMIT+1)th grant
        g0 = grant_log.size();
        c = 0;
        while (grant_log.size() < g0 + 10 && c < 600) begin step(2); c++; end
        inst_req = 1'b0;
        data_req = 1'b0;
        drain();
        for (int k = 0; k < 10; k++)
            if (g0 + k < grant_log.size())
                chk("t3_grant_order", grant_log[g0+k], (k % (LIMIT + 1)) == LIMIT);

        // Long mem_addr_ok stall with a competing inst request
        addr_dly_cfg = 10; data_dly_cfg = 1;
        new_data();
        data_wr = 1'b1;
        step(0); step(0); step(0);
        new_inst();
        drain();
        addr_dly_cfg = 0;

        // Stray mem_data_ok in IDLE and in REQ
        r0 = n_resp;
        stray_idle_arm++;
        repeat (4) step(0);
        chk("t5_stray_idle", 32'(n_resp), 32'(r0));
        stray_req_arm++;
        new_data();
        drain();
        chk("t5_stray_req", 32'(n_resp - r0), 32'd1);

        // Randomized traffic
        rand_dly = 1'b1;
        repeat (600) step(1);
        drain();
        rand_dly = 1'b0;

        // Reset while in WAIT; late response must be dropped
        abort_arm++;
        new_inst();
        c = 0;
        while (!in_wait && c < 50) begin step(0); c++; end
        chk("t6_reach_wait", in_wait, 1'b1);
        lost = 1;
        r0 = n_resp;
        step(0);
        resetn = 1'b0;
        repeat (3) step(0);
        resetn = 1'b1;
        c = 0;
        while (late_done == 0 && c < 50) begin step(0); c++; end
        chk("t6_late_sent", late_done, 1);
        repeat (3) step(0);
        chk("t6_late_dropped", 32'(n_resp), 32'(r0));
        d0 = n_data_ok;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = 32'h1C00_0200; data_wdata = 32'h1234_5678;
        drain();
        chk("t6_write_done", 32'(n_data_ok - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
